// File: rtl/display_sched_pkg.sv
// Shared types and constants for the display request scheduler.
// The FSM state encoding and the code shown on the digit while nothing is granted.
package display_sched_pkg;

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_BLANK} sched_state_t;

   localparam logic [3:0] BLANK_CODE = 4'hF;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: finds the first set request at or after ptr+1,
// ascending with wrap-around.
module rr_priority_picker #(
   parameter int NUM_REQ = 10,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               any,
   output logic [IDX_W-1:0]   winner
);

   logic [IDX_W-1:0] pos;

   // Scan from the far end down so that the nearest candidate is the last to be written.
   always_comb begin
      any    = 1'b0;
      winner = '0;
      pos    = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         pos = IDX_W'((int'(ptr) + 1 + i) % NUM_REQ);
         if (req[pos]) begin
            any    = 1'b1;
            winner = pos;
         end
      end
   end

endmodule

// File: rtl/display_request_scheduler.sv
// Round-robin scheduler sharing one seven-segment digit among switch requesters:
// each grant is held for a fixed window, followed by a blank gap.
module display_request_scheduler
   import display_sched_pkg::*;
#(
   parameter int NUM_REQ      = 10,
   parameter int HOLD_CYCLES  = 25_000_000,
   parameter int BLANK_CYCLES = 2_500_000,
   parameter int IDX_W        = $clog2(NUM_REQ)
) (
   input  logic               Clock,
   input  logic               Resetn,
   input  logic               Enable_I,
   input  logic [NUM_REQ-1:0] Request_I,
   output logic [NUM_REQ-1:0] Grant_O,
   output logic               Grant_valid_O,
   output logic [IDX_W-1:0]   Grant_index_O,
   output logic [3:0]         Display_value_O,
   output logic               Blank_O
);

   localparam int MAX_CYC = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] PTR_RESET  = IDX_W'(NUM_REQ - 1);

   sched_state_t       state, nxt_state;
   logic [CNT_W-1:0]   cnt, nxt_cnt;
   logic [IDX_W-1:0]   ptr, nxt_ptr;
   logic [NUM_REQ-1:0] req_m, req_s;
   logic               any;
   logic [IDX_W-1:0]   winner;
   logic               arbitrate;
   logic               nxt_valid;
   logic [NUM_REQ-1:0] nxt_onehot;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req    (req_s),
      .ptr    (ptr),
      .any    (any),
      .winner (winner)
   );

   // ptr doubles as the granted index: it only changes when a new grant is made.
   always_comb begin
      nxt_state  = state;
      nxt_cnt    = cnt;
      nxt_ptr    = ptr;
      arbitrate  = 1'b0;
      nxt_valid  = 1'b0;
      nxt_onehot = '0;
      case (state)
         S_IDLE: begin
            if (Enable_I) arbitrate = 1'b1;
         end
         S_HOLD: begin
            if (!Enable_I) begin
               nxt_state = S_IDLE;
               nxt_cnt   = '0;
            end else if (!req_s[ptr] || cnt == '0) begin
               if (BLANK_CYCLES == 0) begin
                  arbitrate = 1'b1;
               end else begin
                  nxt_state = S_BLANK;
                  nxt_cnt   = BLANK_LOAD;
               end
            end else begin
               nxt_cnt = cnt - 1'b1;
            end
         end
         S_BLANK: begin
            if (!Enable_I) begin
               nxt_state = S_IDLE;
               nxt_cnt   = '0;
            end else if (cnt == '0) begin
               arbitrate = 1'b1;
            end else begin
               nxt_cnt = cnt - 1'b1;
            end
         end
         default: begin
            nxt_state = S_IDLE;
            nxt_cnt   = '0;
         end
      endcase

      if (arbitrate) begin
         if (any) begin
            nxt_state = S_HOLD;
            nxt_ptr   = winner;
            nxt_cnt   = HOLD_LOAD;
         end else begin
            nxt_state = S_IDLE;
            nxt_cnt   = '0;
         end
      end

      nxt_valid = (nxt_state == S_HOLD);
      if (nxt_valid) nxt_onehot[nxt_ptr] = 1'b1;
   end

   // Outputs are registered from the next-state values so they line up with state.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         req_m           <= '0;
         req_s           <= '0;
         state           <= S_IDLE;
         cnt             <= '0;
         ptr             <= PTR_RESET;
         Grant_O         <= '0;
         Grant_valid_O   <= 1'b0;
         Grant_index_O   <= '0;
         Display_value_O <= BLANK_CODE;
         Blank_O         <= 1'b1;
      end else begin
         req_m           <= Request_I;
         req_s           <= req_m;
         state           <= nxt_state;
         cnt             <= nxt_cnt;
         ptr             <= nxt_ptr;
         Grant_O         <= nxt_onehot;
         Grant_valid_O   <= nxt_valid;
         Grant_index_O   <= nxt_valid ? nxt_ptr : '0;
         Display_value_O <= nxt_valid ? 4'(nxt_ptr) : BLANK_CODE;
         Blank_O         <= !nxt_valid;
      end
   end

endmodule

// File: tb/tb_display_request_scheduler.sv
// Self-checking bench for display_request_scheduler with a grant-order scoreboard
// and hold/gap length monitoring.
module tb_display_request_scheduler;

   localparam int NUM_REQ = 10;
   localparam int HOLD    = 4;
   localparam int BLANK   = 2;
   localparam int IDX_W   = 4;

   logic               Clock;
   logic               Resetn;
   logic               Enable_I;
   logic [NUM_REQ-1:0] Request_I;
   logic [NUM_REQ-1:0] Grant_O;
   logic               Grant_valid_O;
   logic [IDX_W-1:0]   Grant_index_O;
   logic [3:0]         Display_value_O;
   logic               Blank_O;

   int checks = 0;
   int errors = 0;

   logic [IDX_W-1:0] exp_q[$];

   bit mon_en    = 0;
   bit chk_hold  = 0;
   bit chk_gap   = 0;
   bit prev_valid = 0;
   bit has_fall  = 0;
   int hold_cnt  = 0;
   int gap_cnt   = 0;
   logic [IDX_W-1:0]   cur_idx = '0;
   logic [NUM_REQ-1:0] exp_oh;

   display_request_scheduler #(
      .NUM_REQ      (NUM_REQ),
      .HOLD_CYCLES  (HOLD),
      .BLANK_CYCLES (BLANK)
   ) dut (
      .Clock           (Clock),
      .Resetn          (Resetn),
      .Enable_I        (Enable_I),
      .Request_I       (Request_I),
      .Grant_O         (Grant_O),
      .Grant_valid_O   (Grant_valid_O),
      .Grant_index_O   (Grant_index_O),
      .Display_value_O (Display_value_O),
      .Blank_O         (Blank_O)
   );

   // Clock and reset defaults
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Scoreboard monitor: pops the expected index on every new grant and
   // measures hold and gap lengths.
   always @(negedge Clock) begin
      if (!mon_en) begin
         prev_valid = Grant_valid_O;
         has_fall   = 0;
         hold_cnt   = 0;
         gap_cnt    = 0;
      end else begin
         if (Grant_valid_O) begin
            if (!prev_valid) begin
               if (chk_gap && has_fall) begin
                  checks++;
                  if (gap_cnt != BLANK) begin
                     errors++;
                     $display("FAIL gap_len got %0d want %0d", gap_cnt, BLANK);
                  end
               end
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_grant got index %0d want no grant", Grant_index_O);
               end else begin
                  cur_idx = exp_q.pop_front();
                  exp_oh  = '0;
                  exp_oh[cur_idx] = 1'b1;
                  if (Grant_index_O !== cur_idx || Grant_O !== exp_oh) begin
                     errors++;
                     $display("FAIL grant_order got idx %0d onehot %h want idx %0d onehot %h",
                              Grant_index_O, Grant_O, cur_idx, exp_oh);
                  end
               end
               hold_cnt = 0;
            end
            hold_cnt++;
            checks++;
            if (Display_value_O !== 4'(cur_idx) || Blank_O !== 1'b0) begin
               errors++;
               $display("FAIL hold_display got value %h blank %b want value %h blank 0",
                        Display_value_O, Blank_O, 4'(cur_idx));
            end
         end else begin
            if (prev_valid) begin
               has_fall = 1;
               gap_cnt  = 0;
               if (chk_hold) begin
                  checks++;
                  if (hold_cnt != HOLD) begin
                     errors++;
                     $display("FAIL hold_len got %0d want %0d", hold_cnt, HOLD);
                  end
               end
            end
            gap_cnt++;
            checks++;
            if (Blank_O !== 1'b1 || Display_value_O !== 4'hF || Grant_O !== '0) begin
               errors++;
               $display("FAIL blank_outputs got blank %b value %h grant %h want blank 1 value f grant 0",
                        Blank_O, Display_value_O, Grant_O);
            end
         end
         prev_valid = Grant_valid_O;
      end
   end

   // Driver tasks
   task automatic apply_reset();
      @(negedge Clock);
      mon_en   = 0;
      Resetn   = 1'b0;
      Enable_I = 1'b1;
      Request_I = '0;
      exp_q.delete();
      repeat (2) @(negedge Clock);
      Resetn = 1'b1;
   endtask

   task automatic wait_valid(input logic level, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge Clock);
         if (Grant_valid_O === level) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic drain_queue(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge Clock);
         if (exp_q.size() == 0) begin
            ok = 1;
            break;
         end
      end
   endtask

   // Stops a scenario at the end of a full hold without a further grant.
   task automatic end_scenario();
      bit ok;
      wait_valid(1'b0, 50, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL end_timeout got valid stuck high want release within 50 cycles");
      end
      @(negedge Clock);
      Enable_I = 1'b0;
      mon_en   = 0;
      Request_I = '0;
      repeat (4) @(negedge Clock);
      Enable_I = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge Clock);
      Resetn    = 1'b0;
      Enable_I  = 1'b1;
      Request_I = NUM_REQ'($urandom_range(1, 1023));
      repeat (2) @(negedge Clock);
      checks++;
      if (Grant_O !== '0) begin
         errors++;
         $display("FAIL reset_grant got %h want 0", Grant_O);
      end
      checks++;
      if (Display_value_O !== 4'hF) begin
         errors++;
         $display("FAIL reset_display got %h want f", Display_value_O);
      end
      checks++;
      if (Blank_O !== 1'b1) begin
         errors++;
         $display("FAIL reset_blank got %b want 1", Blank_O);
      end
      checks++;
      if (Grant_valid_O !== 1'b0 || Grant_index_O !== '0) begin
         errors++;
         $display("FAIL reset_valid got valid %b idx %0d want 0 0", Grant_valid_O, Grant_index_O);
      end
      Request_I = '0;
      Resetn    = 1'b1;
   endtask

   task automatic test_single();
      bit ok;
      apply_reset();
      chk_hold = 1;
      chk_gap  = 1;
      mon_en   = 1;
      exp_q.push_back(4'd5);
      exp_q.push_back(4'd5);
      exp_q.push_back(4'd5);
      Request_I = 10'h020;
      repeat (2) @(negedge Clock);
      checks++;
      if (Grant_valid_O !== 1'b0) begin
         errors++;
         $display("FAIL single_latency_early got valid %b want 0 after edge 2", Grant_valid_O);
      end
      @(negedge Clock);
      checks++;
      if (Grant_valid_O !== 1'b1 || Grant_index_O !== 4'd5 || Display_value_O !== 4'h5) begin
         errors++;
         $display("FAIL single_latency got valid %b idx %0d value %h want 1 5 5",
                  Grant_valid_O, Grant_index_O, Display_value_O);
      end
      drain_queue(100, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_drain got %0d pending want 0", exp_q.size());
      end
      end_scenario();
   endtask

   task automatic test_round_robin();
      bit ok;
      apply_reset();
      chk_hold = 1;
      chk_gap  = 1;
      mon_en   = 1;
      exp_q.push_back(4'd2);
      exp_q.push_back(4'd7);
      exp_q.push_back(4'd9);
      exp_q.push_back(4'd2);
      Request_I = 10'h284;
      drain_queue(100, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rr_drain got %0d pending want 0", exp_q.size());
      end
      end_scenario();
   endtask

   task automatic test_wrap_around();
      bit ok;
      apply_reset();
      chk_hold = 1;
      chk_gap  = 1;
      mon_en   = 1;
      for (int i = 0; i < NUM_REQ; i++) exp_q.push_back(IDX_W'(i));
      exp_q.push_back(4'd0);
      Request_I = 10'h3FF;
      drain_queue(200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wrap_drain got %0d pending want 0", exp_q.size());
      end
      end_scenario();
   endtask

   task automatic test_early_release();
      bit ok;
      apply_reset();
      chk_hold = 0;
      chk_gap  = 1;
      mon_en   = 1;
      exp_q.push_back(4'd3);
      exp_q.push_back(4'd6);
      Request_I = 10'h048;
      wait_valid(1'b1, 20, ok);
      checks++;
      if (!ok || Grant_index_O !== 4'd3) begin
         errors++;
         $display("FAIL early_first got idx %0d ok %0d want idx 3", Grant_index_O, ok);
      end
      Request_I = 10'h040;
      repeat (2) @(negedge Clock);
      checks++;
      if (Grant_valid_O !== 1'b1 || Grant_index_O !== 4'd3) begin
         errors++;
         $display("FAIL early_still_held got valid %b idx %0d want 1 3", Grant_valid_O, Grant_index_O);
      end
      @(negedge Clock);
      checks++;
      if (Grant_valid_O !== 1'b0 || Blank_O !== 1'b1) begin
         errors++;
         $display("FAIL early_release got valid %b blank %b want 0 1", Grant_valid_O, Blank_O);
      end
      @(negedge Clock);
      checks++;
      if (Blank_O !== 1'b1) begin
         errors++;
         $display("FAIL early_gap got blank %b want 1", Blank_O);
      end
      @(negedge Clock);
      checks++;
      if (Grant_valid_O !== 1'b1 || Grant_index_O !== 4'd6) begin
         errors++;
         $display("FAIL early_next got valid %b idx %0d want 1 6", Grant_valid_O, Grant_index_O);
      end
      // Enable low mid-hold must drop the grant on the very next edge.
      @(negedge Clock);
      Enable_I = 1'b0;
      chk_gap  = 0;
      @(negedge Clock);
      checks++;
      if (Grant_valid_O !== 1'b0 || Blank_O !== 1'b1 || Grant_O !== '0) begin
         errors++;
         $display("FAIL enable_drop got valid %b blank %b grant %h want 0 1 0",
                  Grant_valid_O, Blank_O, Grant_O);
      end
      repeat (3) @(negedge Clock);
      checks++;
      if (Grant_valid_O !== 1'b0) begin
         errors++;
         $display("FAIL enable_idle got valid %b want 0", Grant_valid_O);
      end
      exp_q.push_back(4'd6);
      Enable_I = 1'b1;
      @(negedge Clock);
      checks++;
      if (Grant_valid_O !== 1'b1 || Grant_index_O !== 4'd6) begin
         errors++;
         $display("FAIL idle_regrant got valid %b idx %0d want 1 6", Grant_valid_O, Grant_index_O);
      end
      @(negedge Clock);
      Enable_I  = 1'b0;
      mon_en    = 0;
      Request_I = '0;
      repeat (4) @(negedge Clock);
      Enable_I = 1'b1;
   endtask

   task automatic test_reset_mid_hold();
      bit ok;
      apply_reset();
      Request_I = 10'h080;
      wait_valid(1'b1, 20, ok);
      checks++;
      if (!ok || Grant_index_O !== 4'd7) begin
         errors++;
         $display("FAIL midrst_grant got idx %0d ok %0d want idx 7", Grant_index_O, ok);
      end
      @(negedge Clock);
      Resetn = 1'b0;
      @(negedge Clock);
      checks++;
      if (Grant_O !== '0 || Grant_valid_O !== 1'b0 || Grant_index_O !== '0 ||
          Display_value_O !== 4'hF || Blank_O !== 1'b1) begin
         errors++;
         $display("FAIL midrst_values got grant %h valid %b idx %0d value %h blank %b want 0 0 0 f 1",
                  Grant_O, Grant_valid_O, Grant_index_O, Display_value_O, Blank_O);
      end
      Request_I = 10'h081;
      Resetn    = 1'b1;
      wait_valid(1'b1, 20, ok);
      checks++;
      if (!ok || Grant_index_O !== 4'd0) begin
         errors++;
         $display("FAIL midrst_first got idx %0d ok %0d want idx 0", Grant_index_O, ok);
      end
      @(negedge Clock);
      Enable_I  = 1'b0;
      Request_I = '0;
      repeat (4) @(negedge Clock);
      Enable_I = 1'b1;
   endtask

   initial begin
      Resetn    = 1'b0;
      Enable_I  = 1'b1;
      Request_I = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap_around();
      test_early_release();
      test_reset_mid_hold();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_expected got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_request_scheduler.md
# display_request_scheduler

Round-robin scheduler that shares the single hex-to-seven-segment digit between up to NUM_REQ switch requesters. Each switch is a level request. The block synchronizes the requests and grants one requester at a time for a fixed hold window, followed by a blank gap. It drives the shared digit's 4-bit value: the granted index, or 4'hF when nothing is granted. It sits between SWITCH_I and the convert_hex_to_seven_segment instance in the top level, replacing the static priority encoder.

## Interface
- NUM_REQ, 10: number of requesters; legal range 2..16.
- HOLD_CYCLES, 25_000_000: cycles a grant is held; must be ≥1.
- BLANK_CYCLES, 2_500_000: cycles of blank gap after each grant; 0 means no gap.
- IDX_W, $clog2(NUM_REQ): derived index width.
- Clock  input  1  system clock (50 MHz).
- Resetn  input  1  reset; synchronous and active-low.
- Enable_I  input  1  scheduler enable; level.
- Request_I  input  NUM_REQ  asynchronous level requests (switches).
- Grant_O  output  NUM_REQ  one-hot grant; all zero when no grant.
- Grant_valid_O  output  1  high while in S_HOLD.
- Grant_index_O  output  IDX_W  index of the current grant; 0 when not valid.
- Display_value_O  output  4  feeds the hex converter; zero-extended grant index in S_HOLD, otherwise 4'hF.
- Blank_O  output  1  high in S_IDLE and S_BLANK; the top level forces the digit to 7'h7f when high.

## Operation
- Two-flop synchronizer on Request_I produces req_s. Only req_s is used internally.
- Round-robin pointer ptr holds the last granted index.
  - The search starts at (ptr+1) mod NUM_REQ and ascends with wrap-around.
  - The first set bit of req_s wins.
  - Reset value of ptr is NUM_REQ-1, so the first search starts at index 0.
- FSM states: S_IDLE, S_HOLD, S_BLANK.
  - S_IDLE: if Enable_I and |req_s, register the winner, update ptr, load cnt=HOLD_CYCLES-1, go to S_HOLD. Otherwise stay.
  - S_HOLD, checked in this priority order:
    - If !Enable_I: go to S_IDLE.
    - Else if req_s[granted] is 0 (early release): go to S_BLANK.
    - Else if cnt==0: go to S_BLANK.
    - Else decrement cnt.
  - Entering S_BLANK loads cnt=BLANK_CYCLES-1. If BLANK_CYCLES==0, S_BLANK is bypassed and the next arbitration decision (as in S_BLANK end) is taken directly.
  - S_BLANK:
    - If !Enable_I: go to S_IDLE.
    - Else if cnt==0: if |req_s, grant the winner and go to S_HOLD; otherwise go to S_IDLE.
    - Else decrement cnt.
- A lone requester wraps to itself and is re-granted after each gap.
- Request_I changes during S_HOLD do not preempt the grant, except the granted requester's own release.
- cnt width is $clog2(max(HOLD_CYCLES,BLANK_CYCLES)+1). The counter never underflows.

## Timing
- All outputs are registered.
- Reset values (Resetn low at an edge): Grant_O=0, Grant_valid_O=0, Grant_index_O=0, Display_value_O=4'hF, Blank_O=1, state S_IDLE, cnt=0, ptr=NUM_REQ-1, synchronizer flops=0.
- Reset applied mid-operation behaves identically to power-up reset at the next edge.
- Request latency from IDLE: Request_I stable before edge 1 → req_s high after edge 2 → Grant_O high after edge 3.
- Release latency: Request_I low before edge 1 → Grant_O low and Blank_O high after edge 3.
- Hold duration is exactly HOLD_CYCLES cycles of Grant_valid_O. The gap is exactly BLANK_CYCLES cycles of Blank_O between back-to-back grants.
- Enable_I low takes effect on the next edge, since it is not synchronized. In S_HOLD it overrides early release and cnt==0 in the same cycle.

## Structure
- Package display_sched_pkg holds:
  - typedef enum logic [1:0] {S_IDLE, S_HOLD, S_BLANK} sched_state_t;
  - localparam logic [3:0] BLANK_CODE = 4'hF.
- One combinational sub-module, rr_priority_picker, is parameterized by NUM_REQ.
  - Inputs: req, ptr.
  - Outputs: any, winner index.
- The FSM, counter, pointer and synchronizer live in display_request_scheduler.

## Test plan
All scenarios use NUM_REQ=10, HOLD_CYCLES=4, BLANK_CYCLES=2, Enable_I=1 unless stated.
- Reset: Resetn=0 for 2 edges with random Request_I → Grant_O=0, Display_value_O=4'hF, Blank_O=1, Grant_valid_O=0.
- Single request: Request_I=10'h020 held → after edge 3, Grant_index_O=5 and Display_value_O=4'h5 for 4 cycles. Then Blank_O=1 for 2 cycles, then 5 is re-granted, repeating.
- Round-robin: Request_I bits 2, 7 and 9 held → grant order 2, 7, 9, 2, each 4 cycles with a 2-cycle gap.
- Wrap-around: Request_I=10'h3FF → grant order 0..9 then 0. Display_value_O is never 4'hF during S_HOLD.
- Early release: bit 3 granted, drop Request_I[3] after 1 hold cycle → grant ends 3 edges later, S_BLANK for 2 cycles, then the next requester (bit 6 held) is granted. With Enable_I=0 mid-hold → S_IDLE after 1 edge.
- Reset mid-HOLD: grant on 7, Resetn=0 for 1 edge → reset values at that edge. With Request_I=10'h081, the first grant after release is index 0.
